stage_if: RTL and testbench
===========================

STAGE_IF -- requirements
Module: stage_if

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, the fetch address after reset.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high (RstEnable = 1'b1).
REQ-004 SHALL have port stall_i  input  1  ID stage cannot accept an instruction this cycle.
REQ-005 SHALL have port branch_flag_i  input  1  redirect request from ID (Branch = 1'b1).
REQ-006 SHALL have port branch_addr_i  input  32  redirect target address.
REQ-007 SHALL have port mem_grant_i  input  1  memory controller accepts mem_addr_o this cycle.
REQ-008 SHALL have port mem_byte_i  input  8  read byte, valid the cycle after a granted request.
REQ-009 SHALL have port mem_req_o  output  1  fetch read request.
REQ-010 SHALL have port mem_addr_o  output  32  byte address of the request.
REQ-011 SHALL have port pc_o  output  32  address of the instruction on inst_o.
REQ-012 SHALL have port inst_o  output  32  assembled instruction word.
REQ-013 SHALL have port inst_valid_o  output  1  inst_o/pc_o hold a complete instruction.

Function
REQ-014 SHALL keep a fetch pointer fpc and a state register with states S0, S1, S2, S3 (issue byte k), S4 (await last byte), DONE.
REQ-015 SHALL, in S0..S3, drive mem_req_o=1 and mem_addr_o=fpc+k; on mem_grant_i=1 advance to the next state, else hold state and address.
REQ-016 SHALL set a pending flag and byte index on each granted request and, in the following cycle, store mem_byte_i into inst byte slot index (little-endian: byte 0 -> inst[7:0], byte 3 -> inst[31:24]).
REQ-017 SHALL, in S4, drive mem_req_o=0, capture byte 3, load inst_o and pc_o=fpc, and go to DONE.
REQ-018 SHALL, in DONE, hold inst_valid_o=1 with inst_o and pc_o stable, and mem_req_o=0.
REQ-019 SHALL, in DONE with stall_i=0 and no redirect, consume the instruction: fpc<=fpc+4 (mod 2^32), state<=S0, inst_valid_o<=0.
REQ-020 SHALL, in DONE with stall_i=1, remain in DONE with all outputs unchanged.
REQ-021 SHALL honour a redirect when branch_flag_i=1 and stall_i=0, in any state: fpc<=branch_addr_i, state<=S0, inst_valid_o<=0, pending byte discarded.
REQ-022 SHALL give a redirect priority over consumption when both occur in the same DONE cycle.
REQ-023 SHALL ignore branch_flag_i while stall_i=1.
REQ-024 SHALL, with mem_grant_i held high, raise inst_valid_o exactly 5 cycles after entering S0, for a throughput of one instruction per 6 cycles.
REQ-025 SHALL wrap address arithmetic at 32 bits: fpc=32'hFFFFFFFE issues FFFFFFFE, FFFFFFFF, 00000000, 00000001.
REQ-026 SHALL drive mem_addr_o=32'h0 whenever mem_req_o=0.

Reset
REQ-027 SHALL, on rst=1 at a clock edge, set state=S0, fpc=RESET_PC, pc_o=0, inst_o=0, inst_valid_o=0, mem_req_o=0, mem_addr_o=0 and the pending flag to 0.
REQ-028 SHALL abandon any in-progress fetch on reset and restart at RESET_PC in the cycle after rst deasserts.

Verification
REQ-029 SHALL cover: bytes 13,05,10,00 at address 0, grant always high -> cycle 5 inst_o=32'h00100513, pc_o=0, inst_valid_o=1.
REQ-030 SHALL cover: same setup with stall_i=1 for cycles 5-8 -> outputs frozen through cycle 8; cycle 10 mem_addr_o=4.
REQ-031 SHALL cover: grant low on the cycle S2 is entered -> mem_addr_o=2 held until granted; valid is delayed by 1 cycle.
REQ-032 SHALL cover: branch_flag_i=1 with branch_addr_i=32'h100 during S2 -> next cycle mem_addr_o=32'h100, inst_valid_o=0; the old pending byte is not written.
REQ-033 SHALL cover: redirect coincident with consumption in DONE -> fetch resumes at branch_addr_i, not pc+4.
REQ-034 SHALL cover: rst=1 during S3 -> next cycle all outputs at reset values; the fetch after release is from RESET_PC.

Source files
------------

// File: rtl/stage_if.sv
// Instruction fetch stage: assembles a 32-bit little-endian instruction from four
// byte reads over a granted memory port, then holds it until ID consumes or redirects.
module stage_if #(
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_addr_i,
    input  logic        mem_grant_i,
    input  logic [7:0]  mem_byte_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        inst_valid_o
);

    typedef enum logic [2:0] {
        StS0   = 3'd0,
        StS1   = 3'd1,
        StS2   = 3'd2,
        StS3   = 3'd3,
        StS4   = 3'd4,
        StDone = 3'd5
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] fpc_q, fpc_d;
    logic        run_q, run_d;
    logic        pend_q, pend_d;
    logic [1:0]  pend_idx_q, pend_idx_d;
    logic [23:0] asm_q, asm_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;

    logic        is_issue;
    logic [1:0]  byte_idx;
    logic        redirect;

    // run_q keeps the request low for the cycle in which reset is still being released
    always_comb begin
        is_issue   = (state_q == StS0) || (state_q == StS1) ||
                     (state_q == StS2) || (state_q == StS3);
        byte_idx   = state_q[1:0];
        mem_req_o  = run_q && is_issue;
        mem_addr_o = mem_req_o ? (fpc_q + {30'd0, byte_idx}) : 32'h0;
        redirect   = branch_flag_i && !stall_i;
    end

    always_comb begin
        state_d    = state_q;
        fpc_d      = fpc_q;
        run_d      = 1'b1;
        pend_d     = 1'b0;
        pend_idx_d = pend_idx_q;
        asm_d      = asm_q;
        inst_d     = inst_q;
        pc_d       = pc_q;
        valid_d    = valid_q;

        if (redirect) begin
            fpc_d   = branch_addr_i;
            state_d = StS0;
            valid_d = 1'b0;
        end else begin
            if (pend_q) begin
                unique case (pend_idx_q)
                    2'd0: asm_d[7:0]   = mem_byte_i;
                    2'd1: asm_d[15:8]  = mem_byte_i;
                    2'd2: asm_d[23:16] = mem_byte_i;
                    default: ;
                endcase
            end

            unique case (state_q)
                StS0, StS1, StS2, StS3: begin
                    if (mem_req_o && mem_grant_i) begin
                        pend_d     = 1'b1;
                        pend_idx_d = byte_idx;
                        state_d    = state_e'(state_q + 3'd1);
                    end
                end
                StS4: begin
                    // Byte 3 arrives this cycle and goes straight into the output word
                    inst_d  = {mem_byte_i, asm_q};
                    pc_d    = fpc_q;
                    valid_d = 1'b1;
                    state_d = StDone;
                end
                StDone: begin
                    if (!stall_i) begin
                        fpc_d   = fpc_q + 32'd4;
                        state_d = StS0;
                        valid_d = 1'b0;
                    end
                end
                default: state_d = StS0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StS0;
            fpc_q      <= RESET_PC;
            run_q      <= 1'b0;
            pend_q     <= 1'b0;
            pend_idx_q <= 2'd0;
            asm_q      <= 24'd0;
            inst_q     <= 32'd0;
            pc_q       <= 32'd0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            fpc_q      <= fpc_d;
            run_q      <= run_d;
            pend_q     <= pend_d;
            pend_idx_q <= pend_idx_d;
            asm_q      <= asm_d;
            inst_q     <= inst_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
        end
    end

    assign pc_o         = pc_q;
    assign inst_o       = inst_q;
    assign inst_valid_o = valid_q;

endmodule

// File: tb/tb_stage_if.sv
// Bench for stage_if: directed vector table, hand sequences for multi-cycle corners,
// and randomized traffic against a transaction-level fetch model.
module tb_stage_if;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        branch_flag_i;
    logic [31:0] branch_addr_i;
    logic        mem_grant_i;
    logic [7:0]  mem_byte_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        inst_valid_o;

    stage_if #(.RESET_PC(32'h00000000)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall_i      (stall_i),
        .branch_flag_i(branch_flag_i),
        .branch_addr_i(branch_addr_i),
        .mem_grant_i  (mem_grant_i),
        .mem_byte_i   (mem_byte_i),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .pc_o         (pc_o),
        .inst_o       (inst_o),
        .inst_valid_o (inst_valid_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Transaction-level model: bytes granted so far, whether a word is held, its pc/data
    bit          mchk = 1'b0;
    bit          m_run;
    logic [31:0] m_fpc;
    int          m_issued;
    bit          m_valid;
    logic [31:0] m_pc;
    logic [31:0] m_inst;
    bit          rsp_v = 1'b0;
    logic [31:0] rsp_a = 32'h0;

    function automatic logic [7:0] mem_rd(input logic [31:0] a);
        case (a)
            32'd0:   return 8'h13;
            32'd1:   return 8'h05;
            32'd2:   return 8'h10;
            32'd3:   return 8'h00;
            default: return (a[7:0] * 8'd29) ^ a[15:8] ^ a[31:24] ^ 8'h3C;
        endcase
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {mem_rd(a + 32'd3), mem_rd(a + 32'd2), mem_rd(a + 32'd1), mem_rd(a)};
    endfunction

    function automatic bit m_req();
        return m_run && !m_valid && (m_issued < 4);
    endfunction

    function automatic logic [31:0] m_addr();
        return m_req() ? (m_fpc + 32'(m_issued)) : 32'h0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic apply(input logic st, input logic br, input logic [31:0] ba,
                         input logic gr, input logic rs);
        @(negedge clk);
        stall_i       = st;
        branch_flag_i = br;
        branch_addr_i = ba;
        mem_grant_i   = gr;
        rst           = rs;
        mem_byte_i    = rsp_v ? mem_rd(rsp_a) : 8'($urandom);
        if (mchk) begin
            chk("model_req", {31'd0, mem_req_o}, {31'd0, m_req()});
            chk("model_addr", mem_addr_o, m_addr());
            chk("model_valid", {31'd0, inst_valid_o}, {31'd0, m_valid});
            if (m_valid) begin
                chk("model_pc", pc_o, m_pc);
                chk("model_inst", inst_o, m_inst);
            end
        end
    endtask

    task automatic tick();
        bit req;
        logic [31:0] addr;
        @(posedge clk);
        req   = m_req();
        addr  = m_addr();
        rsp_v = req && mem_grant_i;
        rsp_a = addr;
        if (rst) begin
            m_run = 0; m_fpc = 32'h0; m_issued = 0; m_valid = 0;
            m_pc = 32'h0; m_inst = 32'h0;
            mchk = 1'b1;
        end else begin
            m_run = 1;
            if (branch_flag_i && !stall_i) begin
                m_fpc = branch_addr_i; m_issued = 0; m_valid = 0;
            end else if (m_valid) begin
                if (!stall_i) begin
                    m_fpc = m_fpc + 32'd4; m_issued = 0; m_valid = 0;
                end
            end else if (m_issued == 4) begin
                m_valid = 1; m_pc = m_fpc; m_inst = mem_word(m_fpc);
            end else if (req && mem_grant_i) begin
                m_issued++;
            end
        end
    endtask

    // Leaves the bench just before cycle 0 (first request cycle after reset)
    task automatic reset_seq();
        apply(0, 0, 0, 1, 1); tick();
        apply(0, 0, 0, 1, 1);
        chk("rst_req", {31'd0, mem_req_o}, 32'd0);
        chk("rst_addr", mem_addr_o, 32'd0);
        chk("rst_valid", {31'd0, inst_valid_o}, 32'd0);
        chk("rst_pc", pc_o, 32'd0);
        chk("rst_inst", inst_o, 32'd0);
        tick();
        apply(0, 0, 0, 1, 0);
        chk("release_req", {31'd0, mem_req_o}, 32'd0);
        tick();
    endtask

    typedef struct {
        logic        st;
        logic        gr;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_inst;
    } vec_t;

    vec_t tbl[12];

    initial begin
        stall_i = 0; branch_flag_i = 0; branch_addr_i = 0; mem_grant_i = 0;
        mem_byte_i = 0; rst = 1;

        // Basic fetch at 0 with stall on cycles 5-8, consume at 9
        tbl[0]  = '{0, 1, 1, 32'h0, 0, 32'h0, 32'h0};
        tbl[1]  = '{0, 1, 1, 32'h1, 0, 32'h0, 32'h0};
        tbl[2]  = '{0, 1, 1, 32'h2, 0, 32'h0, 32'h0};
        tbl[3]  = '{0, 1, 1, 32'h3, 0, 32'h0, 32'h0};
        tbl[4]  = '{0, 1, 0, 32'h0, 0, 32'h0, 32'h0};
        tbl[5]  = '{1, 1, 0, 32'h0, 1, 32'h0, 32'h00100513};
        tbl[6]  = '{1, 1, 0, 32'h0, 1, 32'h0, 32'h00100513};
        tbl[7]  = '{1, 1, 0, 32'h0, 1, 32'h0, 32'h00100513};
        tbl[8]  = '{1, 1, 0, 32'h0, 1, 32'h0, 32'h00100513};
        tbl[9]  = '{0, 1, 0, 32'h0, 1, 32'h0, 32'h00100513};
        tbl[10] = '{0, 1, 1, 32'h4, 0, 32'h0, 32'h0};
        tbl[11] = '{0, 1, 1, 32'h5, 0, 32'h0, 32'h0};

        reset_seq();
        for (int i = 0; i < 12; i++) begin
            apply(tbl[i].st, 0, 0, tbl[i].gr, 0);
            chk($sformatf("tbl%0d_req", i), {31'd0, mem_req_o}, {31'd0, tbl[i].exp_req});
            chk($sformatf("tbl%0d_addr", i), mem_addr_o, tbl[i].exp_addr);
            chk($sformatf("tbl%0d_valid", i), {31'd0, inst_valid_o}, {31'd0, tbl[i].exp_valid});
            if (tbl[i].exp_valid) begin
                chk($sformatf("tbl%0d_pc", i), pc_o, tbl[i].exp_pc);
                chk($sformatf("tbl%0d_inst", i), inst_o, tbl[i].exp_inst);
            end
            tick();
        end

        // Grant withheld on entry to S2: address held, valid one cycle late
        reset_seq();
        apply(0, 0, 0, 1, 0); tick();
        apply(0, 0, 0, 1, 0); tick();
        apply(0, 0, 0, 0, 0); chk("hold_addr_a", mem_addr_o, 32'h2); tick();
        apply(0, 0, 0, 1, 0); chk("hold_addr_b", mem_addr_o, 32'h2); tick();
        apply(0, 0, 0, 1, 0); chk("hold_addr_c", mem_addr_o, 32'h3); tick();
        apply(0, 0, 0, 1, 0); chk("hold_valid5", {31'd0, inst_valid_o}, 32'd0); tick();
        apply(0, 0, 0, 1, 0);
        chk("hold_valid6", {31'd0, inst_valid_o}, 32'd1);
        chk("hold_inst", inst_o, 32'h00100513);
        tick();

        // Redirect during S2
        reset_seq();
        apply(0, 0, 0, 1, 0); tick();
        apply(0, 0, 0, 1, 0); tick();
        apply(0, 1, 32'h100, 1, 0); tick();
        apply(0, 0, 0, 1, 0);
        chk("br_addr", mem_addr_o, 32'h100);
        chk("br_valid", {31'd0, inst_valid_o}, 32'd0);
        tick();
        for (int i = 0; i < 4; i++) begin
            apply(0, 0, 0, 1, 0); tick();
        end
        apply(1, 0, 0, 1, 0);
        chk("br_done_valid", {31'd0, inst_valid_o}, 32'd1);
        chk("br_done_pc", pc_o, 32'h100);
        chk("br_done_inst", inst_o, mem_word(32'h100));
        tick();

        // Redirect coincident with consumption
        reset_seq();
        for (int i = 0; i < 5; i++) begin
            apply(0, 0, 0, 1, 0); tick();
        end
        apply(0, 1, 32'h200, 1, 0);
        chk("bc_valid", {31'd0, inst_valid_o}, 32'd1);
        tick();
        apply(0, 0, 0, 1, 0); chk("bc_addr", mem_addr_o, 32'h200); tick();

        // Reset in S3 of the second fetch
        reset_seq();
        for (int i = 0; i < 9; i++) begin
            apply(0, 0, 0, 1, 0); tick();
        end
        apply(0, 0, 0, 1, 1); chk("rs_s3_addr", mem_addr_o, 32'h7); tick();
        apply(0, 0, 0, 1, 0);
        chk("rs_req", {31'd0, mem_req_o}, 32'd0);
        chk("rs_addr", mem_addr_o, 32'd0);
        chk("rs_valid", {31'd0, inst_valid_o}, 32'd0);
        chk("rs_pc", pc_o, 32'd0);
        chk("rs_inst", inst_o, 32'd0);
        tick();
        apply(0, 0, 0, 1, 0);
        chk("rs_restart_req", {31'd0, mem_req_o}, 32'd1);
        chk("rs_restart_addr", mem_addr_o, 32'd0);
        tick();

        // Address wrap at 32 bits
        reset_seq();
        apply(0, 1, 32'hFFFFFFFE, 1, 0); tick();
        apply(0, 0, 0, 1, 0); chk("wrap_a0", mem_addr_o, 32'hFFFFFFFE); tick();
        apply(0, 0, 0, 1, 0); chk("wrap_a1", mem_addr_o, 32'hFFFFFFFF); tick();
        apply(0, 0, 0, 1, 0); chk("wrap_a2", mem_addr_o, 32'h00000000); tick();
        apply(0, 0, 0, 1, 0); chk("wrap_a3", mem_addr_o, 32'h00000001); tick();
        apply(0, 0, 0, 1, 0); tick();
        apply(0, 0, 0, 1, 0);
        chk("wrap_pc", pc_o, 32'hFFFFFFFE);
        chk("wrap_inst", inst_o, mem_word(32'hFFFFFFFE));
        tick();
        apply(0, 0, 0, 1, 0); chk("wrap_next", mem_addr_o, 32'h00000002); tick();

        // Randomized traffic against the model
        reset_seq();
        for (int i = 0; i < 3000; i++) begin
            logic        st, br, gr, rs;
            logic [31:0] ba;
            st = ($urandom_range(0, 9) < 3);
            br = ($urandom_range(0, 19) == 0);
            gr = ($urandom_range(0, 3) != 0);
            rs = ($urandom_range(0, 199) == 0);
            ba = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF8 + 32'($urandom_range(0, 7)))
                                             : $urandom;
            apply(st, br, ba, gr, rs);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
